// File: rtl/usb_cdc_upload_mux_if.sv
// Channel-side and upload-side signal bundle of the CDC upload aggregator.
interface usb_cdc_upload_mux_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH*8-1:0] ch_data_in;
  logic [NUM_CH-1:0]   ch_valid_in;
  logic [NUM_CH-1:0]   ch_ready_out;
  logic [NUM_CH-1:0]   ch_overflow_out;
  logic                clear_overflow_in;
  logic [7:0]          up_data_out;
  logic                up_valid_out;
  logic                up_ready_in;
  logic                busy_out;

  // master: the aggregator itself
  modport master (
    input  ch_data_in, ch_valid_in, clear_overflow_in, up_ready_in,
    output ch_ready_out, ch_overflow_out, up_data_out, up_valid_out, busy_out
  );

  // slave: the channel producers and the EP2 upload sink
  modport slave (
    output ch_data_in, ch_valid_in, clear_overflow_in, up_ready_in,
    input  ch_ready_out, ch_overflow_out, up_data_out, up_valid_out, busy_out
  );
endinterface

// File: rtl/usb_cdc_upload_mux.sv
// Multi-channel upload aggregator: per-channel FIFOs, idle-timeout flush,
// round-robin arbitration and framed output (SYNC, CHID, LEN, payload, CSUM).
module usb_cdc_upload_mux #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FIFO_DEPTH    = 64,
  parameter int unsigned MAX_PAYLOAD   = 32,
  parameter int unsigned FLUSH_TIMEOUT = 6000,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input logic                  PHY_CLKOUT,
  input logic                  RESET,
  usb_cdc_upload_mux_if.master bus
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TW   = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CHID, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t            state;
  logic [7:0]        mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [CNTW-1:0]   count  [NUM_CH];
  logic [TW-1:0]     timer  [NUM_CH];
  logic [NUM_CH-1:0] ovf, ready_vec, eligible, wr_acc, pop_vec, done_vec;
  logic [CW-1:0]     rr_ptr, ch_id, grant_ch;
  logic [7:0]        len, left, csum, grant_len, head;
  logic              grant_found, accept, pop;

  assign accept = bus.up_valid_out & bus.up_ready_in;
  // The next payload byte is fetched when the byte ahead of it is accepted,
  // so the FIFO head is already in the output register with no bubble.
  assign pop  = accept & ((state == S_LEN) | ((state == S_PAYLOAD) & (left != '0)));
  assign head = mem[ch_id][rd_ptr[ch_id]];

  assign bus.ch_ready_out    = ready_vec;
  assign bus.ch_overflow_out = ovf;
  assign bus.busy_out        = (state != S_IDLE);

  // Per-channel write acceptance, pop/frame-done decode and flush eligibility
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      pop_vec[n]   = pop && (ch_id == CW'(n));
      done_vec[n]  = accept && (state == S_CSUM) && (ch_id == CW'(n));
      ready_vec[n] = (count[n] != CNTW'(FIFO_DEPTH));
      wr_acc[n]    = bus.ch_valid_in[n] && (ready_vec[n] || pop_vec[n]);
      eligible[n]  = (count[n] >= CNTW'(MAX_PAYLOAD)) ||
                     ((count[n] != '0) && (timer[n] == TW'(FLUSH_TIMEOUT)));
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = rr_ptr;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!grant_found && eligible[CW'((32'(rr_ptr) + i) % NUM_CH)]) begin
        grant_found = 1'b1;
        grant_ch    = CW'((32'(rr_ptr) + i) % NUM_CH);
      end
    end
    grant_len = (count[grant_ch] >= CNTW'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD)
                                                        : 8'(count[grant_ch]);
  end

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge PHY_CLKOUT) begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (wr_acc[n]) mem[n][wr_ptr[n]] <= bus.ch_data_in[8*n +: 8];
    end
  end

  // FIFO pointers and counts, idle timers and sticky overflow flags
  always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
    if (RESET) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
        timer[n]  <= '0;
      end
      ovf <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_acc[n])  wr_ptr[n] <= wr_ptr[n] + 1'b1;
        if (pop_vec[n]) rd_ptr[n] <= rd_ptr[n] + 1'b1;
        if (wr_acc[n] && !pop_vec[n])      count[n] <= count[n] + 1'b1;
        else if (!wr_acc[n] && pop_vec[n]) count[n] <= count[n] - 1'b1;
        if (wr_acc[n] || done_vec[n]) timer[n] <= '0;
        else if (count[n] != '0) begin
          if (timer[n] != TW'(FLUSH_TIMEOUT)) timer[n] <= timer[n] + 1'b1;
        end else timer[n] <= '0;
        // a drop on the same cycle as a clear leaves the flag set
        if (bus.ch_valid_in[n] && !wr_acc[n]) ovf[n] <= 1'b1;
        else if (bus.clear_overflow_in)       ovf[n] <= 1'b0;
      end
    end
  end

  // Framing FSM with registered output byte/valid; advances only on acceptance
  always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
    if (RESET) begin
      state            <= S_IDLE;
      rr_ptr           <= CW'(NUM_CH - 1);
      ch_id            <= '0;
      len              <= '0;
      left             <= '0;
      csum             <= '0;
      bus.up_valid_out <= 1'b0;
      bus.up_data_out  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (grant_found) begin
          state            <= S_SYNC;
          ch_id            <= grant_ch;
          rr_ptr           <= grant_ch;
          len              <= grant_len;
          bus.up_valid_out <= 1'b1;
          bus.up_data_out  <= SYNC_BYTE;
        end
        S_SYNC: if (accept) begin
          state           <= S_CHID;
          bus.up_data_out <= 8'(ch_id);
          csum            <= 8'(ch_id);
        end
        S_CHID: if (accept) begin
          state           <= S_LEN;
          bus.up_data_out <= len;
          csum            <= csum ^ len;
        end
        S_LEN: if (accept) begin
          state           <= S_PAYLOAD;
          bus.up_data_out <= head;
          csum            <= csum ^ head;
          left            <= len - 8'd1;
        end
        S_PAYLOAD: if (accept) begin
          if (left == '0) begin
            state           <= S_CSUM;
            bus.up_data_out <= csum;
          end else begin
            bus.up_data_out <= head;
            csum            <= csum ^ head;
            left            <= left - 8'd1;
          end
        end
        S_CSUM: if (accept) begin
          state            <= S_IDLE;
          bus.up_valid_out <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_cdc_upload_mux.sv
// Bench for usb_cdc_upload_mux: queue/frame-list model checked every cycle,
// plus hand-computed frame contents for the directed scenarios.
module tb_usb_cdc_upload_mux;
  localparam int unsigned NUM_CH = 4;
  localparam int          DEPTH  = 64;
  localparam int          MAXP   = 32;
  localparam int          TO     = 6000;
  localparam logic [7:0]  SYNC   = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  usb_cdc_upload_mux_if #(.NUM_CH(NUM_CH)) bus ();

  usb_cdc_upload_mux #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .MAX_PAYLOAD(MAXP),
    .FLUSH_TIMEOUT(TO), .SYNC_BYTE(SYNC)
  ) dut (
    .PHY_CLKOUT(clk),
    .RESET(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: circular byte stores plus a whole-frame list ----
  logic [7:0]        mbuf [NUM_CH][DEPTH];
  int                mhead [NUM_CH];
  int                msize [NUM_CH];
  int                mtimer[NUM_CH];
  logic [NUM_CH-1:0] movf;
  int                mptr, fj, fch, flen;
  bit                infr;
  logic              mvalid;
  logic [7:0]        mdata;
  logic [7:0]        frame[$];

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      mhead[n] = 0; msize[n] = 0; mtimer[n] = 0;
    end
    movf = '0; mptr = NUM_CH - 1; infr = 0; mvalid = 1'b0; mdata = 8'h00;
    fj = 0; fch = 0; flen = 0; frame.delete();
  endtask

  task automatic model_step();
    int old_size[NUM_CH];
    int old_tmr[NUM_CH];
    int g, c;
    bit acc, wr, was_idle;
    logic [NUM_CH-1:0] popv, donev;
    logic [7:0] cs, b;
    for (int n = 0; n < NUM_CH; n++) begin
      old_size[n] = msize[n]; old_tmr[n] = mtimer[n];
    end
    was_idle = !infr;
    g = -1;
    if (was_idle) begin
      for (int i = 1; i <= NUM_CH && g < 0; i++) begin
        c = (mptr + i) % NUM_CH;
        if (old_size[c] >= MAXP || (old_size[c] > 0 && old_tmr[c] == TO)) g = c;
      end
    end
    acc = mvalid && bus.up_ready_in;
    popv = '0; donev = '0;
    if (infr && acc) begin
      if (fj + 1 < frame.size()) begin
        fj++;
        mdata = frame[fj];
        if (fj >= 3 && fj < 3 + flen) popv[fch] = 1'b1;
      end else begin
        infr = 0; mvalid = 1'b0; donev[fch] = 1'b1;
      end
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (popv[n]) begin
        mhead[n] = (mhead[n] + 1) % DEPTH; msize[n]--;
      end
      wr = bus.ch_valid_in[n] && (old_size[n] < DEPTH || popv[n]);
      if (bus.clear_overflow_in) movf[n] = 1'b0;
      if (bus.ch_valid_in[n] && !wr) movf[n] = 1'b1;
      if (wr) begin
        mbuf[n][(mhead[n] + msize[n]) % DEPTH] = bus.ch_data_in[8*n +: 8];
        msize[n]++;
      end
      if (wr || donev[n]) mtimer[n] = 0;
      else if (old_size[n] > 0) mtimer[n] = (old_tmr[n] + 1 > TO) ? TO : old_tmr[n] + 1;
      else mtimer[n] = 0;
    end
    if (g >= 0) begin
      flen = (old_size[g] < MAXP) ? old_size[g] : MAXP;
      frame.delete();
      frame.push_back(SYNC);
      frame.push_back(8'(g));
      frame.push_back(8'(flen));
      cs = 8'(g) ^ 8'(flen);
      for (int k = 0; k < flen; k++) begin
        b = mbuf[g][(mhead[g] + k) % DEPTH];
        frame.push_back(b);
        cs = cs ^ b;
      end
      frame.push_back(cs);
      fch = g; mptr = g; fj = 0; infr = 1; mvalid = 1'b1; mdata = SYNC;
    end
  endtask

  function automatic logic [NUM_CH-1:0] mready();
    logic [NUM_CH-1:0] r;
    for (int n = 0; n < NUM_CH; n++) r[n] = (msize[n] < DEPTH);
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare and accepted-byte log -----------------
  logic [7:0] log_q[$];
  bit         prev_hold = 0;
  logic [7:0] prev_data;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("valid", bus.up_valid_out, mvalid);
      check("busy", bus.busy_out, infr);
      check("ch_ready", bus.ch_ready_out, mready());
      check("ch_overflow", bus.ch_overflow_out, movf);
      if (mvalid) check("data", bus.up_data_out, mdata);
      if (prev_hold) check("hold", {bus.up_valid_out, bus.up_data_out}, {1'b1, prev_data});
      if (bus.up_valid_out && bus.up_ready_in) log_q.push_back(bus.up_data_out);
      prev_hold = bus.up_valid_out && !bus.up_ready_in;
      prev_data = bus.up_data_out;
    end else prev_hold = 0;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.up_valid_out && n < 7000) begin
      tick(); n++;
    end
  endtask

  int         n;
  logic [7:0] expv[$];

  initial begin
    bus.ch_data_in = '0; bus.ch_valid_in = '0; bus.clear_overflow_in = 1'b0;
    bus.up_ready_in = 1'b1;
    tick(); tick();
    check("rst_ready", bus.ch_ready_out, 4'hF);
    check("rst_ovf", bus.ch_overflow_out, 4'h0);
    check("rst_valid", bus.up_valid_out, 1'b0);
    check("rst_data", bus.up_data_out, 8'h00);
    check("rst_busy", bus.busy_out, 1'b0);
    rst = 1'b0;

    // 32-byte burst on channel 0
    log_q.delete();
    for (int i = 0; i < 32; i++) begin
      bus.ch_valid_in = 4'b0001; bus.ch_data_in = '0; bus.ch_data_in[7:0] = 8'(i); tick();
    end
    bus.ch_valid_in = '0;
    repeat (45) tick();
    check("t1_len", log_q.size(), 36);
    check("t1_sync", log_q[0], 8'hA5);
    check("t1_chid", log_q[1], 8'h00);
    check("t1_plen", log_q[2], 8'h20);
    check("t1_pay7", log_q[10], 8'h07);
    check("t1_pay31", log_q[34], 8'h1F);
    check("t1_csum", log_q[35], 8'h20);
    check("t1_busy", bus.busy_out, 1'b0);

    // partial fill on channel 2, flushed by the idle timer
    log_q.delete();
    bus.ch_data_in = '0;
    bus.ch_valid_in = 4'b0100; bus.ch_data_in[23:16] = 8'h11; tick();
    bus.ch_data_in[23:16] = 8'h22; tick();
    bus.ch_data_in[23:16] = 8'h33; tick();
    bus.ch_valid_in = '0;
    wait_valid(n);
    check("t2_wait", n, 6001);
    repeat (10) tick();
    expv = '{8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
    check("t2_len", log_q.size(), 7);
    for (int k = 0; k < 7; k++) check("t2_byte", log_q[k], expv[k]);

    // channels 0, 1, 3 full together; channel 0 refilled meanwhile
    do_reset();
    log_q.delete();
    for (int i = 0; i < 32; i++) begin
      bus.ch_valid_in = 4'b1011;
      bus.ch_data_in = '0;
      bus.ch_data_in[7:0]   = 8'(i);
      bus.ch_data_in[15:8]  = 8'(64 + i);
      bus.ch_data_in[31:24] = 8'(192 + i);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      bus.ch_valid_in = 4'b0001; bus.ch_data_in = '0; bus.ch_data_in[7:0] = 8'(128 + i); tick();
    end
    bus.ch_valid_in = '0;
    repeat (170) tick();
    check("t3_len", log_q.size(), 144);
    check("t3_chid0", log_q[1], 8'h00);
    check("t3_chid1", log_q[37], 8'h01);
    check("t3_chid2", log_q[73], 8'h03);
    check("t3_chid3", log_q[109], 8'h00);
    check("t3_ch1_first", log_q[39], 8'h40);
    check("t3_refill_first", log_q[111], 8'h80);

    // ready toggling during a channel 1 frame
    log_q.delete();
    for (int i = 0; i < 32; i++) begin
      bus.ch_valid_in = 4'b0010; bus.ch_data_in = '0; bus.ch_data_in[15:8] = 8'(8'hC0 + i); tick();
    end
    bus.ch_valid_in = '0;
    for (int i = 0; i < 100; i++) begin
      bus.up_ready_in = ~bus.up_ready_in; tick();
    end
    bus.up_ready_in = 1'b1;
    repeat (5) tick();
    expv.delete();
    expv.push_back(8'hA5); expv.push_back(8'h01); expv.push_back(8'h20);
    for (int i = 0; i < 32; i++) expv.push_back(8'(8'hC0 + i));
    expv.push_back(8'h21);
    check("t4_len", log_q.size(), 36);
    for (int k = 0; k < 36; k++) check("t4_byte", log_q[k], expv[k]);

    // overflow with the sink stalled
    do_reset();
    log_q.delete();
    bus.up_ready_in = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.ch_valid_in = 4'b0010; bus.ch_data_in = '0; bus.ch_data_in[15:8] = 8'(i);
      bus.clear_overflow_in = (i == 66);
      tick();
      if (i == 63) begin
        check("t5_ready_full", bus.ch_ready_out[1], 1'b0);
        check("t5_ovf_before", bus.ch_overflow_out[1], 1'b0);
      end
      if (i == 64) check("t5_ovf_set", bus.ch_overflow_out[1], 1'b1);
      if (i == 66) check("t5_ovf_set_wins", bus.ch_overflow_out[1], 1'b1);
    end
    bus.ch_valid_in = '0; bus.clear_overflow_in = 1'b1; tick();
    bus.clear_overflow_in = 1'b0;
    check("t5_ovf_cleared", bus.ch_overflow_out[1], 1'b0);
    bus.up_ready_in = 1'b1;
    repeat (100) tick();
    check("t5_len", log_q.size(), 72);
    check("t5_first", log_q[3], 8'h00);
    check("t5_last", log_q[70], 8'd63);

    // reset in the middle of a payload, then a 1-byte flush frame
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus.ch_valid_in = 4'b0001; bus.ch_data_in = '0; bus.ch_data_in[7:0] = 8'(i + 1); tick();
    end
    bus.ch_valid_in = '0;
    repeat (9) tick();
    check("t6_mid_busy", bus.busy_out, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", bus.up_valid_out, 1'b0);
    check("t6_rst_data", bus.up_data_out, 8'h00);
    check("t6_rst_busy", bus.busy_out, 1'b0);
    check("t6_rst_ready", bus.ch_ready_out, 4'hF);
    check("t6_rst_ovf", bus.ch_overflow_out, 4'h0);
    tick();
    rst = 1'b0;
    log_q.delete();
    bus.ch_valid_in = 4'b1000; bus.ch_data_in = '0; bus.ch_data_in[31:24] = 8'h5A; tick();
    bus.ch_valid_in = '0;
    wait_valid(n);
    check("t6_wait", n, 6001);
    repeat (10) tick();
    expv = '{8'hA5, 8'h03, 8'h01, 8'h5A, 8'h58};
    check("t6_len", log_q.size(), 5);
    for (int k = 0; k < 5; k++) check("t6_byte", log_q[k], expv[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_cdc_upload_mux.md
Name: usb_cdc_upload_mux

Overview:
- Parametrised multi-channel upload aggregator for the USB CDC data path, clocked in the PHY_CLKOUT (60 MHz) domain.
- Accepts NUM_CH independent byte streams, each into its own FIFO.
- Round-robin arbitrates between channels and emits framed packets on one byte stream. That stream drives the EP2 upload interface (usb_upload_data_in / usb_upload_valid_in).
- Replaces the single-stream upload connection; adds per-channel buffering, idle-timeout flush, framing, checksum and overflow reporting.

Parameters:
- NUM_CH, 4: number of input channels, 1..16.
- FIFO_DEPTH, 64: bytes per channel FIFO; must be a power of 2, at least 4.
- MAX_PAYLOAD, 32: maximum payload bytes per frame, 1..255, and at most FIFO_DEPTH.
- FLUSH_TIMEOUT, 6000: idle cycles before a partially filled channel is flushed (100 us at 60 MHz); at least 1.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- PHY_CLKOUT  in  1  clock, 60 MHz.
- RESET  in  1  reset, asynchronous, active-high.
- ch_data_in  in  NUM_CH*8  channel n byte on bits [8n+7:8n].
- ch_valid_in  in  NUM_CH  write strobe for channel n, one byte per cycle.
- ch_ready_out  out  NUM_CH  channel n FIFO not full.
- ch_overflow_out  out  NUM_CH  sticky flag: a byte was dropped on channel n.
- clear_overflow_in  in  1  clears all overflow flags.
- up_data_out  out  8  framed output byte.
- up_valid_out  out  1  up_data_out is valid.
- up_ready_in  in  1  sink accepts the byte; tie to 1 for EP2.
- busy_out  out  1  a frame is in progress (FSM state is not IDLE).

Behaviour:
- Reset is asynchronous, active-high, clock is PHY_CLKOUT, as already decided.
- Reset values:
  - all FIFOs empty, all counts 0, all timers 0;
  - ch_ready_out all 1s, ch_overflow_out 0, up_valid_out 0, up_data_out 8'h00, busy_out 0;
  - FSM in IDLE; round-robin pointer at channel NUM_CH-1, so channel 0 has first priority.
- Channel FIFO:
  - A write when ch_valid_in[n]=1 and the FIFO is not full stores the byte and increments the count.
  - A write to a full FIFO drops the byte and sets ch_overflow_out[n].
  - A write and a read on the same FIFO in the same cycle leave the count unchanged, including at full; the write is accepted at full only if the read also occurs in that cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- Overflow clear: clear_overflow_in clears all flags. If a set and a clear occur on the same cycle for a channel, the set wins.
- Idle timer, per channel:
  - resets to 0 on an accepted write, or when a frame for that channel finishes;
  - otherwise increments while count>0, saturating at FLUSH_TIMEOUT;
  - holds at 0 while count=0.
- Eligibility: channel n is eligible when count>=MAX_PAYLOAD, or when count>0 and its timer equals FLUSH_TIMEOUT.
- Arbitration:
  - In IDLE, the first eligible channel after the round-robin pointer is granted, searching cyclically.
  - On grant, the block latches ch_id and len = min(count, MAX_PAYLOAD), moves the pointer to ch_id, and goes to SYNC.
  - If no channel is eligible, the FSM stays in IDLE.
- Framing FSM: IDLE -> SYNC -> CHID -> LEN -> PAYLOAD -> CSUM -> IDLE.
- Bytes emitted in each state:
  - SYNC emits SYNC_BYTE.
  - CHID emits {4'h0, ch_id}.
  - LEN emits len.
  - PAYLOAD emits len bytes popped from FIFO[ch_id] in order, one per accepted transfer.
  - CSUM emits the XOR of the CHID, LEN and all payload bytes.
- Output handshake:
  - A byte transfers on a cycle with up_valid_out=1 and up_ready_in=1.
  - up_valid_out and up_data_out are registered and held stable until accepted.
  - The state advances only on an accepted transfer.
  - Back-to-back frames are allowed: CSUM accepted -> IDLE (1 cycle, up_valid_out=0) -> next SYNC.
- Latency: from an eligible channel in IDLE, SYNC appears on up_valid_out 1 cycle later. With up_ready_in held at 1, a frame takes len+4 cycles.
- Writes during a frame:
  - Writes to the channel being drained are allowed. They never lengthen the latched len and stay in the FIFO for a later frame.
  - The FIFO pop for payload byte k occurs on acceptance of the preceding byte, so data is ready with no bubble (first-word fall-through read).
- Output reset mid-frame: RESET aborts the frame immediately and returns the block to reset values. No partial-frame recovery is required.

Test Plan:
- Burst of 32 bytes 0x00..0x1F on channel 0, up_ready_in=1 -> the frame starts immediately with A5 00 20, then 00..1F, then checksum 0x20 (00^20^XOR(00..1F)=0x20); the frame is 36 bytes and busy_out drops after CSUM.
- 3 bytes 11 22 33 on channel 2, then idle -> no output for 6000 cycles, then A5 02 03 11 22 33 with checksum 0x02^0x03^0x11^0x22^0x33=0x01.
- Channels 0, 1 and 3 all filled to 32 at the same time -> frames are emitted in order ch0, ch1, ch3. A refill of ch0 during those frames is served only after ch3.
- up_ready_in toggling 1/0 every cycle during a frame -> byte order and values match the case with up_ready_in=1, and up_data_out is stable whenever up_ready_in=0.
- up_ready_in=0 while 70 bytes are written to channel 1 -> ch_ready_out[1]=0 after byte 64, ch_overflow_out[1]=1 and 6 bytes are dropped. clear_overflow_in asserted on the same cycle as a drop keeps the flag at 1.
- RESET asserted in the middle of PAYLOAD -> on the next cycle all outputs are at their reset values, and a new 1-byte flush frame afterwards is correct.
